// File: rtl/regf_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regf_xfer_ctrl
//  Purpose  : Block-transfer sequencer between the register file and a host
//             stream port. Dump mode reads consecutive registers and presents
//             them on a valid/ready output stream. Load mode accepts words
//             from a valid/ready input stream and writes them into
//             consecutive registers. Addresses wrap modulo 2**ADDR_W.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, dir, base,   - transfer request and its parameters,
//             len                   sampled only while idle
//             busy, done          - status (done is a one-cycle pulse)
//             rf_addr, rf_we,     - register-file master port
//             rf_wdata, rf_rdata    (read data valid the cycle after rf_addr)
//             out_data/valid/ready- dump stream
//             in_data/valid/ready - load stream
//  Revision : 1.0 - initial release
// ============================================================================
module regf_xfer_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_OUT   = 3'd3,
    S_LD    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] C_CNT_ONE = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W-1:0] addr_hold;  // last address driven, shown while not accessing
  logic [DATA_W-1:0] data_q;     // dump word captured from the register file

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      cnt       <= '0;
      addr_hold <= '0;
      data_q    <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
      if (state == S_RD || state == S_LD) begin
        addr_hold <= addr;
      end
      // Read data belongs to the address driven in the preceding RD cycle.
      if (state == S_RWAIT) begin
        data_q <= rf_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          addr_nxt = base;
          cnt_nxt  = len;
          if (len == '0) begin
            state_nxt = S_DONE;
          end else if (dir) begin
            state_nxt = S_LD;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          addr_nxt  = addr + 1'b1;
          cnt_nxt   = cnt - 1'b1;
          state_nxt = (cnt == C_CNT_ONE) ? S_DONE : S_RD;
        end
      end
      S_LD: begin
        if (in_valid) begin
          addr_nxt = addr + 1'b1;
          cnt_nxt  = cnt - 1'b1;
          if (cnt == C_CNT_ONE) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Everything is forced low while rst is high so that a reset
  // landing mid-load cannot issue one more write in the reset cycle itself.
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rf_addr   = '0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    out_data  = '0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    if (!rst) begin
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
      out_data = data_q;
      rf_addr  = (state == S_RD || state == S_LD) ? addr : addr_hold;
      case (state)
        S_OUT: begin
          out_valid = 1'b1;
        end
        S_LD: begin
          in_ready = 1'b1;
          rf_we    = in_valid;
          rf_wdata = in_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regf_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regf_xfer_ctrl
//  Purpose  : Self-checking bench for regf_xfer_ctrl. Holds a register-file
//             model and an independent expected-contents array; transfers
//             are checked word by word against plain modulo arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regf_xfer_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // backdoor port used only to preload the register-file model
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  logic [DATA_W-1:0] regf   [NREG];
  logic [DATA_W-1:0] exp_rf [NREG];

  int checks = 0;
  int errors = 0;

  regf_xfer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rf_addr   (rf_addr),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, registered read (data next cycle).
  always @(posedge clk) begin
    if (bd_we) regf[bd_addr] <= bd_data;
    else if (rf_we) regf[rf_addr] <= rf_wdata;
    rf_rdata <= regf[rf_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_drive();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer. exp_done < 0 skips the exact-latency check.
  // Random start/dir/base/len noise is driven while busy; it must be ignored.
  task automatic do_xfer(input logic d, input int b, input int l,
                         input int rdy_pct, input int vld_pct, input int exp_done);
    int k;
    int cyc;
    bit seen_done;
    k = 0;
    seen_done = 0;
    step_drive();
    start = 1'b1; dir = d; base = 4'(b); len = 5'(l);
    in_valid = 1'b0; out_ready = 1'b0; in_data = $urandom;
    @(negedge clk);
    check("idle_before_start", {31'b0, busy}, 32'd0);
    for (cyc = 1; cyc < 400 && !seen_done; cyc++) begin
      step_drive();
      start     = 1'($urandom % 2);
      dir       = 1'($urandom % 2);
      base      = 4'($urandom);
      len       = 5'($urandom % 17);
      in_valid  = ($urandom % 100) < 32'(vld_pct);
      in_data   = $urandom;
      out_ready = ($urandom % 100) < 32'(rdy_pct);
      @(negedge clk);
      if (done) begin
        seen_done = 1;
        check("words_at_done", 32'(k), 32'(l));
        check("busy_at_done", {31'b0, busy}, 32'd1);
        if (exp_done >= 0) check("done_latency", 32'(cyc), 32'(exp_done));
      end else if (d) begin
        check("no_out_valid_load", {31'b0, out_valid}, 32'd0);
        if (in_ready) begin
          check("load_we", {31'b0, rf_we}, {31'b0, in_valid});
          if (in_valid) begin
            check("load_addr", {28'b0, rf_addr}, 32'((b + k) % NREG));
            check("load_wdata", rf_wdata, in_data);
            exp_rf[(b + k) % NREG] = in_data;
            k++;
          end
        end else begin
          check("no_we_outside_ld", {31'b0, rf_we}, 32'd0);
        end
      end else begin
        check("no_we_dump", {31'b0, rf_we}, 32'd0);
        check("no_in_ready_dump", {31'b0, in_ready}, 32'd0);
        if (out_valid) begin
          check("dump_data", out_data, exp_rf[(b + k) % NREG]);
          if (out_ready) k++;
        end
      end
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    step_drive();
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_done", {30'b0, busy, done}, 32'd0);
    for (int i = 0; i < NREG; i++) check("regf_contents", regf[i], exp_rf[i]);
  endtask

  typedef struct {
    logic d;
    int   b;
    int   l;
    int   exp_done;  // cycle after start where done pulses, full throughput
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [DATA_W-1:0] held;
    int w;
    vecs[0] = '{d: 1'b1, b: 2,  l: 3,  exp_done: 4};
    vecs[1] = '{d: 1'b0, b: 0,  l: 2,  exp_done: 7};
    vecs[2] = '{d: 1'b1, b: 15, l: 2,  exp_done: 3};
    vecs[3] = '{d: 1'b1, b: 7,  l: 0,  exp_done: 1};
    vecs[4] = '{d: 1'b0, b: 9,  l: 0,  exp_done: 1};
    vecs[5] = '{d: 1'b1, b: 0,  l: 16, exp_done: 17};
    vecs[6] = '{d: 1'b0, b: 14, l: 4,  exp_done: 13};
    vecs[7] = '{d: 1'b0, b: 5,  l: 16, exp_done: 49};

    // Reset with an active request on every input; preload the regfile model.
    rst = 1'b1; start = 1'b1; dir = 1'b1; base = 4'd3; len = 5'd3;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      step_drive();
      bd_we = 1'b1; bd_addr = 4'(i);
      bd_data = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : $urandom;
      exp_rf[i] = bd_data;
      @(negedge clk);
      if (i < 2) begin
        check("reset_status", {30'b0, busy, done}, 32'd0);
        check("reset_rf", {27'b0, rf_we, rf_addr}, 32'd0);
        check("reset_wdata", rf_wdata, 32'd0);
        check("reset_stream", {30'b0, out_valid, in_ready}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
      end
    end
    step_drive();
    bd_we = 1'b0; rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {30'b0, busy, done}, 32'd0);

    // Table-driven transfers at full throughput.
    for (int i = 0; i < 8; i++) do_xfer(vecs[i].d, vecs[i].b, vecs[i].l, 100, 100, vecs[i].exp_done);

    // Dump backpressure: word must hold for 5 stalled cycles.
    step_drive();
    start = 1'b1; dir = 1'b0; base = 4'd3; len = 5'd1; out_ready = 1'b0;
    w = 0;
    do begin
      step_drive();
      start = 1'b0;
      @(negedge clk);
      w++;
    end while (!out_valid && w < 10);
    check("bp_valid_seen", {31'b0, out_valid}, 32'd1);
    held = out_data;
    check("bp_data", held, exp_rf[3]);
    for (int i = 0; i < 5; i++) begin
      step_drive();
      @(negedge clk);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_data", out_data, held);
    end
    step_drive();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", {31'b0, out_valid}, 32'd1);
    step_drive();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_done", {30'b0, done, out_valid}, 32'd2);
    step_drive();
    @(negedge clk);
    check("bp_idle", {31'b0, busy}, 32'd0);

    // Reset after the first of three load words.
    step_drive();
    start = 1'b1; dir = 1'b1; base = 4'd6; len = 5'd3; in_valid = 1'b0;
    step_drive();
    start = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0001;
    @(negedge clk);
    check("abort_first_we", {27'b0, rf_we, rf_addr}, 32'h16);
    exp_rf[6] = 32'hA5A5_0001;
    step_drive();
    rst = 1'b1; in_data = 32'hA5A5_0002;
    @(negedge clk);
    check("abort_rst_cycle", {29'b0, rf_we, busy, in_ready}, 32'd0);
    step_drive();
    rst = 1'b0; in_data = 32'hA5A5_0003;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_idle", {29'b0, busy, done, rf_we}, 32'd0);
      step_drive();
    end
    in_valid = 1'b0;
    for (int i = 0; i < NREG; i++) check("abort_regf", regf[i], exp_rf[i]);

    // Randomized transfers with random stalls.
    for (int t = 0; t < 20; t++) begin
      do_xfer(1'($urandom % 2), int'($urandom % 16), int'($urandom % 17),
              int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
